// File: rtl/uart_stream_controller_if.sv
`timescale 1ns/1ps
// Signal bundle between the UART stream controller and the board-level bench
// (push button, serial pins, message source and display buffer).
interface uart_stream_controller_if #(
  parameter int MSG_LEN    = 5,
  parameter int DISP_DEPTH = 6
);
  logic                    i_enable;
  logic                    i_send_n;
  logic                    i_clear;
  logic                    i_rx;
  logic [8*MSG_LEN-1:0]    i_msg;
  logic                    o_tx;
  logic                    o_tx_busy;
  logic [7:0]              o_rx_data;
  logic                    o_rx_valid;
  logic                    o_frame_err;
  logic [8*DISP_DEPTH-1:0] o_disp;

  modport slave (
    input  i_enable, i_send_n, i_clear, i_rx, i_msg,
    output o_tx, o_tx_busy, o_rx_data, o_rx_valid, o_frame_err, o_disp
  );

  modport master (
    output i_enable, i_send_n, i_clear, i_rx, i_msg,
    input  o_tx, o_tx_busy, o_rx_data, o_rx_valid, o_frame_err, o_disp
  );
endinterface

// File: rtl/uart_stream_controller.sv
`timescale 1ns/1ps
// 8N1 UART controller: sends an i_msg string on a button press and shifts good
// received bytes into a display buffer. Baud timing from a shared tick enable.
module uart_stream_controller #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int MSG_LEN    = 5,
  parameter int DISP_DEPTH = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  uart_stream_controller_if.slave bus
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int IDX_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  logic [1:0]       send_sync_q, send_sync_d;
  logic             send_prev_q, send_prev_d;
  logic             send_fall;
  logic [1:0]       rx_sync_q, rx_sync_d;
  logic             rx_s;

  tx_state_e        tx_state_q, tx_state_d;
  logic [OS_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d, tx_idx_inc;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_bit_end;

  rx_state_e               rx_state_q, rx_state_d;
  logic [OS_W-1:0]         rx_cnt_q, rx_cnt_d;
  logic [2:0]              rx_bit_q, rx_bit_d;
  logic [7:0]              rx_shift_q, rx_shift_d;
  logic [7:0]              rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic [8*DISP_DEPTH-1:0] disp_q, disp_d, disp_shifted;

  // Synchronisers, button edge detect and the free-running tick divider.
  always_comb begin
    send_sync_d = {send_sync_q[0], bus.i_send_n};
    send_prev_d = send_sync_q[1];
    send_fall   = send_prev_q & ~send_sync_q[1];
    rx_sync_d   = {rx_sync_q[0], bus.i_rx};
    rx_s        = rx_sync_q[1];
    tick        = bus.i_enable && (div_cnt_q == DIV_LAST);
    div_cnt_d   = div_cnt_q;
    if (bus.i_enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
  end

  assign tx_idx_inc = tx_idx_q + 1'b1;
  assign tx_bit_end = tick && (tx_cnt_q == OS_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;

    if (tx_state_q != TX_IDLE && tick) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    end

    unique case (tx_state_q)
      TX_IDLE: begin
        // Busy while still in IDLE means a request is waiting for its first tick.
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (send_fall) begin
          tx_busy_d = 1'b1;
        end
        if ((tx_busy_q || send_fall) && tick) begin
          tx_state_d = TX_START;
          tx_line_d  = 1'b0;
          tx_shift_d = bus.i_msg[7:0];
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_idx_q != IDX_LAST) begin
            tx_state_d = TX_START;
            tx_idx_d   = tx_idx_inc;
            tx_line_d  = 1'b0;
            tx_shift_d = bus.i_msg[{tx_idx_inc, 3'b000} +: 8];
          end else begin
            tx_state_d = TX_IDLE;
            tx_idx_d   = '0;
            tx_busy_d  = 1'b0;
            tx_line_d  = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (!bus.i_enable) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      tx_idx_d   = '0;
      tx_busy_d  = 1'b0;
      tx_line_d  = 1'b1;
    end
  end

  always_comb begin
    disp_shifted = '0;
    for (int unsigned i = 1; i < DISP_DEPTH; i++) begin
      disp_shifted[8*i +: 8] = disp_q[8*(i-1) +: 8];
    end
    disp_shifted[7:0] = rx_shift_q;
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    disp_d      = disp_q;

    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (tick && !rx_s) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_cnt_q == OS_HALF) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) begin
              rx_state_d = RX_STOP;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d = '0;
            if (rx_s) begin
              rx_state_d = RX_IDLE;
              rx_valid_d = 1'b1;
              rx_data_d  = rx_shift_q;
              disp_d     = disp_shifted;
            end else begin
              rx_state_d  = RX_WAIT_HIGH;
              frame_err_d = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_s) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (bus.i_clear) begin
      disp_d = '0;
    end

    if (!bus.i_enable) begin
      rx_state_d  = RX_IDLE;
      rx_cnt_d    = '0;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt_q   <= '0;
      send_sync_q <= '1;
      send_prev_q <= 1'b1;
      rx_sync_q   <= '1;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_line_q   <= 1'b1;
      tx_busy_q   <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      send_sync_q <= send_sync_d;
      send_prev_q <= send_prev_d;
      rx_sync_q   <= rx_sync_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      tx_line_q   <= tx_line_d;
      tx_busy_q   <= tx_busy_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      disp_q      <= disp_d;
    end
  end

  assign bus.o_tx        = tx_line_q;
  assign bus.o_tx_busy   = tx_busy_q;
  assign bus.o_rx_data   = rx_data_q;
  assign bus.o_rx_valid  = rx_valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_disp      = disp_q;

endmodule
